// File: rtl/vga_timing_pkg.sv
// 640x480@60Hz raster timing constants shared by the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned CNT_W           = 10;

  localparam int unsigned VGA_CLK_DIV     = 4;
  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_ACT_START = 144;
  localparam int unsigned VGA_H_ACT_END   = 784;
  localparam int unsigned VGA_V_TOTAL     = 525;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_ACT_START = 35;
  localparam int unsigned VGA_V_ACT_END   = 515;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD wrap counter; wrap flags the terminal count (independent of en).
module mod_counter #(
  parameter int unsigned MOD = 2,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == W'(MOD - 1));

  // Advance on enable, returning to zero after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: sync, visible window, pixel strobe and frame/move ticks.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV         = VGA_CLK_DIV,
  parameter int unsigned H_TOTAL         = VGA_H_TOTAL,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_ACT_START     = VGA_H_ACT_START,
  parameter int unsigned H_ACT_END       = VGA_H_ACT_END,
  parameter int unsigned V_TOTAL         = VGA_V_TOTAL,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_ACT_START     = VGA_V_ACT_START,
  parameter int unsigned V_ACT_END       = VGA_V_ACT_END,
  parameter int unsigned FRAMES_PER_MOVE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             pix_en,
  output logic             frame_tick,
  output logic             move_tick
);

  cnt_t div;
  cnt_t fcnt;
  logic div_wrap;
  logic h_wrap;
  logic v_wrap;
  logic f_wrap;
  logic frame_wrap;
  logic unused_cnt;

  // Divider and frame counts only matter through their wrap flags.
  assign unused_cnt = ^{div, fcnt};

  mod_counter #(.MOD(CLK_DIV), .W(CNT_W)) u_div (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(div), .wrap(div_wrap)
  );

  assign pix_en = div_wrap;

  mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_h (
    .clk(clk), .rst(rst), .en(pix_en), .cnt(hCount), .wrap(h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_v (
    .clk(clk), .rst(rst), .en(pix_en & h_wrap), .cnt(vCount), .wrap(v_wrap)
  );

  assign frame_wrap = pix_en & h_wrap & v_wrap;

  // Frozen frames neither advance the move divider nor fire move_tick.
  mod_counter #(.MOD(FRAMES_PER_MOVE), .W(CNT_W)) u_frame (
    .clk(clk), .rst(rst), .en(frame_wrap & ~freeze), .cnt(fcnt), .wrap(f_wrap)
  );

  assign hSync  = !(hCount < CNT_W'(H_SYNC));
  assign vSync  = !(vCount < CNT_W'(V_SYNC));
  assign bright = (hCount >= CNT_W'(H_ACT_START)) && (hCount < CNT_W'(H_ACT_END)) &&
                  (vCount >= CNT_W'(V_ACT_START)) && (vCount < CNT_W'(V_ACT_END));

  // Ticks land on the cycle where the raster sits at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
      move_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      move_tick  <= frame_wrap & ~freeze & f_wrap;
    end
  end

endmodule
